// File: rtl/sram_pkg.sv
// Shared types and constants for the masked single-port SRAM model.
package sram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] LFSR_SEED = 32'h00000001;

  // Galois right-shift step; taps 32,22,2,1 give a maximal-length sequence.
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    lfsr_step = {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_POLY : 32'h00000000);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline: RD_LAT (1 or 2) register stages, output data held
// between returns or reloaded from idle_data when idle_load is set.
module sram_rd_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  idle_load,
  input  logic [DATA_WIDTH-1:0] idle_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  last_valid_s;
  logic [DATA_WIDTH-1:0] last_data_s;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic                  mid_valid_r;
      logic [DATA_WIDTH-1:0] mid_data_r;

      // Extra stage for the two-cycle latency option.
      always_ff @(posedge clk) begin
        if (reset) begin
          mid_valid_r <= 1'b0;
          mid_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
          mid_valid_r <= in_valid;
          mid_data_r  <= in_data;
        end
      end

      assign last_valid_s = mid_valid_r;
      assign last_data_s  = mid_data_r;
    end else begin : g_lat1
      assign last_valid_s = in_valid;
      assign last_data_s  = in_data;
    end
  endgenerate

  // Output stage: load on a return, otherwise hold or show idle data.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      out_valid_r <= last_valid_s;
      if (last_valid_s) begin
        out_data_r <= last_data_s;
      end else if (idle_load) begin
        out_data_r <= idle_data;
      end else begin
        out_data_r <= out_data_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: rtl/sram_1p_mask_pipe.sv
// Single-port SRAM with per-lane write mask, zero-fill INIT state and
// pipelined reads. Optional macro: SRAM_GARBAGE_RDATA_EN (LFSR idle data).
module sram_1p_mask_pipe
  import sram_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int DATA_WIDTH = 64,
  parameter int LANE_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                             RW0_clk,
  input  logic                             RW0_reset,
  input  logic                             RW0_en,
  input  logic                             RW0_wmode,
  input  logic [$clog2(DEPTH)-1:0]         RW0_addr,
  input  logic [DATA_WIDTH-1:0]            RW0_wdata,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] RW0_wmask,
  input  logic                             clear_req,
  output logic                             RW0_ready,
  output logic [DATA_WIDTH-1:0]            RW0_rdata,
  output logic                             RW0_rvalid,
  output logic                             init_done
);

  localparam int              LANES     = DATA_WIDTH / LANE_WIDTH;
  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_L   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  sram_state_e           state_r;
  sram_state_e           state_next_s;
  logic [AW-1:0]         fill_cnt_r;
  logic [AW-1:0]         fill_cnt_next_s;
  logic                  fill_we_s;
  logic                  ready_r;
  logic                  accept_s;
  logic                  addr_ok_s;
  logic                  wr_s;
  logic                  rd_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  idle_load_s;
  logic [DATA_WIDTH-1:0] idle_data_s;

  // State and fill counter registers; ready mirrors the next state.
  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      state_r    <= ST_INIT;
      fill_cnt_r <= {AW{1'b0}};
      ready_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      fill_cnt_r <= fill_cnt_next_s;
      ready_r    <= (state_next_s == ST_READY);
    end
  end

  // Next-state logic: INIT walks every address once, READY waits for clear.
  always_comb begin
    state_next_s    = state_r;
    fill_cnt_next_s = fill_cnt_r;
    fill_we_s       = 1'b0;
    case (state_r)
      ST_INIT: begin
        fill_we_s = 1'b1;
        if (fill_cnt_r == LAST_ADDR) begin
          state_next_s    = ST_READY;
          fill_cnt_next_s = {AW{1'b0}};
        end else begin
          fill_cnt_next_s = fill_cnt_r + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_next_s    = ST_INIT;
          fill_cnt_next_s = {AW{1'b0}};
        end else begin
          state_next_s    = ST_READY;
        end
      end
      default: begin
        state_next_s    = ST_INIT;
        fill_cnt_next_s = {AW{1'b0}};
      end
    endcase
  end

  // Request decode; read data is sampled in the accept cycle so a write
  // committed on the previous edge is already visible.
  always_comb begin
    accept_s  = RW0_en & ready_r & ~RW0_reset;
    addr_ok_s = ({1'b0, RW0_addr} < DEPTH_L);
    wr_s      = accept_s & RW0_wmode & addr_ok_s;
    rd_s      = accept_s & ~RW0_wmode;
    if (addr_ok_s) begin
      rd_word_s = mem[RW0_addr];
    end else begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Array write port: zero-fill during INIT, masked lane writes in READY.
  always_ff @(posedge RW0_clk) begin
    if (fill_we_s) begin
      mem[fill_cnt_r] <= {DATA_WIDTH{1'b0}};
    end else if (wr_s) begin
      for (int l = 0; l < LANES; l++) begin
        if (RW0_wmask[l]) begin
          mem[RW0_addr][l*LANE_WIDTH +: LANE_WIDTH] <= RW0_wdata[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

`ifdef SRAM_GARBAGE_RDATA_EN
  logic [31:0]           lfsr_r;
  logic [DATA_WIDTH-1:0] garbage_s;

  // Free-running LFSR used to poison rdata between returns.
  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  // Replicate the 32-bit LFSR across the data width.
  always_comb begin
    garbage_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      garbage_s[i] = lfsr_r[i % 32];
    end
  end

  assign idle_load_s = 1'b1;
  assign idle_data_s = garbage_s;
`else
  assign idle_load_s = 1'b0;
  assign idle_data_s = {DATA_WIDTH{1'b0}};
`endif

  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LAT     (RD_LAT)
  ) u_rd_pipe (
    .clk       (RW0_clk),
    .reset     (RW0_reset),
    .in_valid  (rd_s),
    .in_data   (rd_word_s),
    .idle_load (idle_load_s),
    .idle_data (idle_data_s),
    .out_valid (RW0_rvalid),
    .out_data  (RW0_rdata)
  );

  assign RW0_ready = ready_r;
  assign init_done = ready_r;

endmodule

// File: tb/tb_sram_1p_mask_pipe.sv
// Bench: two instances (DEPTH 16 / RD_LAT 1 and DEPTH 12 / RD_LAT 2) share
// stimulus; a per-instance memory array and pending-read list give expectations.
module tb_sram_1p_mask_pipe;

  localparam int DEP [2] = '{16, 12};
  localparam int LAT [2] = '{1, 2};

  logic        clk = 1'b0;
  logic        rst, en, wmode, clr;
  logic [3:0]  addr;
  logic [63:0] wdata;
  logic [7:0]  wmask;

  logic        ready_a, ready_b, done_a, done_b, rv_a, rv_b;
  logic [63:0] rdata_a, rdata_b;

  always #5 clk = ~clk;

  sram_1p_mask_pipe #(.DEPTH(16), .DATA_WIDTH(64), .LANE_WIDTH(8), .RD_LAT(1)) dut_a (
    .RW0_clk(clk), .RW0_reset(rst), .RW0_en(en), .RW0_wmode(wmode), .RW0_addr(addr),
    .RW0_wdata(wdata), .RW0_wmask(wmask), .clear_req(clr), .RW0_ready(ready_a),
    .RW0_rdata(rdata_a), .RW0_rvalid(rv_a), .init_done(done_a));

  sram_1p_mask_pipe #(.DEPTH(12), .DATA_WIDTH(64), .LANE_WIDTH(8), .RD_LAT(2)) dut_b (
    .RW0_clk(clk), .RW0_reset(rst), .RW0_en(en), .RW0_wmode(wmode), .RW0_addr(addr),
    .RW0_wdata(wdata), .RW0_wmask(wmask), .clear_req(clr), .RW0_ready(ready_b),
    .RW0_rdata(rdata_b), .RW0_rvalid(rv_b), .init_done(done_b));

  typedef struct {
    int          k;
    int          due;
    logic [63:0] d;
  } rd_t;

  rd_t         pend[$];
  logic [63:0] mem_m [2][16];
  bit          rdy_m [2];
  int          left_m [2];
  logic [63:0] last_m [2];
  logic [63:0] prev_rd [2];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic drive(input logic r, input logic e, input logic w, input logic [3:0] a,
                       input logic [63:0] d, input logic [7:0] m, input logic c);
    logic        got_rdy, got_done, got_rv, hit;
    logic [63:0] got_rd, exp_d;
    rst = r; en = e; wmode = w; addr = a; wdata = d; wmask = m; clr = c;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        rdy_m[k]  = 1'b0;
        left_m[k] = DEP[k];
        last_m[k] = 64'h0;
      end else if (rdy_m[k]) begin
        if (e && !w) begin
          pend.push_back('{k, cyc + LAT[k], (int'(a) < DEP[k]) ? mem_m[k][a] : 64'h0});
        end else if (e && w && int'(a) < DEP[k]) begin
          for (int l = 0; l < 8; l++)
            if (m[l]) mem_m[k][a][l*8 +: 8] = d[l*8 +: 8];
        end
        if (c) begin
          rdy_m[k]  = 1'b0;
          left_m[k] = DEP[k];
        end
      end else begin
        left_m[k]--;
        if (left_m[k] == 0) begin
          rdy_m[k] = 1'b1;
          for (int i = 0; i < 16; i++) mem_m[k][i] = 64'h0;
        end
      end
    end
    if (r) pend.delete();
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      got_rdy  = (k == 0) ? ready_a : ready_b;
      got_done = (k == 0) ? done_a  : done_b;
      got_rv   = (k == 0) ? rv_a    : rv_b;
      got_rd   = (k == 0) ? rdata_a : rdata_b;
      n_checks++;
      if (got_rdy !== rdy_m[k]) begin
        n_fail++;
        $display("FAIL ready inst%0d cyc %0d: got %0b expected %0b", k, cyc, got_rdy, rdy_m[k]);
      end
      n_checks++;
      if (got_done !== rdy_m[k]) begin
        n_fail++;
        $display("FAIL init_done inst%0d cyc %0d: got %0b expected %0b", k, cyc, got_done, rdy_m[k]);
      end
      hit = 1'b0;
      exp_d = 64'h0;
      foreach (pend[i]) if (pend[i].k == k && pend[i].due == cyc) begin hit = 1'b1; exp_d = pend[i].d; end
      n_checks++;
      if (got_rv !== hit) begin
        n_fail++;
        $display("FAIL rvalid inst%0d cyc %0d: got %0b expected %0b", k, cyc, got_rv, hit);
      end
      if (hit) begin
        n_checks++;
        if (got_rd !== exp_d) begin
          n_fail++;
          $display("FAIL rdata inst%0d cyc %0d: got %h expected %h", k, cyc, got_rd, exp_d);
        end
        last_m[k] = exp_d;
      end else if (r) begin
        n_checks++;
        if (got_rd !== 64'h0) begin
          n_fail++;
          $display("FAIL rdata_reset inst%0d cyc %0d: got %h expected 0", k, cyc, got_rd);
        end
      end else begin
        n_checks++;
`ifdef SRAM_GARBAGE_RDATA_EN
        if (got_rd === prev_rd[k]) begin
          n_fail++;
          $display("FAIL rdata_garbage inst%0d cyc %0d: got %h expected a change from %h", k, cyc, got_rd, prev_rd[k]);
        end
`else
        if (got_rd !== last_m[k]) begin
          n_fail++;
          $display("FAIL rdata_hold inst%0d cyc %0d: got %h expected %h", k, cyc, got_rd, last_m[k]);
        end
`endif
      end
      prev_rd[k] = got_rd;
    end
    for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].due <= cyc) pend.delete(i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 4'h0, 64'h0, 8'h00, 1'b0);
  endtask

  task automatic wait_ready();
    int budget = 64;
    while (!(rdy_m[0] && rdy_m[1]) && budget > 0) begin
      idle(1);
      budget--;
    end
    n_checks++;
    if (!(rdy_m[0] && rdy_m[1])) begin
      n_fail++;
      $display("FAIL wait_ready cyc %0d: got not ready expected ready within budget", cyc);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 4'h0, 64'h0, 8'h00, 1'b0);
    idle(17);
  endtask

  task automatic test_init_zero();
    for (int a = 0; a < 16; a++) drive(1'b0, 1'b1, 1'b0, 4'(a), 64'h0, 8'h00, 1'b0);
    idle(3);
  endtask

  task automatic test_mask_merge();
    drive(1'b0, 1'b1, 1'b1, 4'd3, 64'h1122334455667788, 8'hFF, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 64'h0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 4'd3, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 64'h0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 4'd13, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd13, 64'h0, 8'h00, 1'b0);
    idle(3);
  endtask

  task automatic test_write_read_next();
    drive(1'b0, 1'b1, 1'b1, 4'd5, 64'hDEAD, 8'hFF, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd5, 64'h0, 8'h00, 1'b0);
    idle(3);
  endtask

  task automatic test_back_to_back_clear();
    for (int a = 0; a < 4; a++) drive(1'b0, 1'b1, 1'b1, 4'(a), {$urandom, $urandom}, 8'hFF, 1'b0);
    for (int a = 0; a < 4; a++) drive(1'b0, 1'b1, 1'b0, 4'(a), 64'h0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 64'h0, 8'h00, 1'b1);
    idle(18);
    for (int a = 0; a < 4; a++) drive(1'b0, 1'b1, 1'b0, 4'(a), 64'h0, 8'h00, 1'b0);
    idle(3);
  endtask

  task automatic test_reset_mid_init();
    drive(1'b0, 1'b1, 1'b1, 4'd1, 64'hCAFEF00D12345678, 8'hFF, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd1, 64'h0, 8'h00, 1'b1);
    idle(5);
    drive(1'b1, 1'b1, 1'b0, 4'd1, 64'h0, 8'h00, 1'b0);
    idle(18);
    wait_ready();
    drive(1'b0, 1'b1, 1'b0, 4'd1, 64'h0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 64'h0, 8'h00, 1'b0);
    idle(18);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), {$urandom, $urandom}, 8'($urandom_range(0, 255)),
            ($urandom_range(0, 39) == 0));
    idle(20);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wmode = 1'b0; clr = 1'b0;
    addr = 4'h0; wdata = 64'h0; wmask = 8'h00;
    for (int k = 0; k < 2; k++) begin
      rdy_m[k] = 1'b0; left_m[k] = DEP[k]; last_m[k] = 64'h0; prev_rd[k] = 64'h0;
      for (int i = 0; i < 16; i++) mem_m[k][i] = 64'h0;
    end
    test_reset();
    wait_ready();
    test_init_zero();
    test_mask_merge();
    test_write_read_next();
    test_back_to_back_clear();
    wait_ready();
    test_reset_mid_init();
    wait_ready();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
